// File: rtl/md_unit.sv
// Multiply/divide execute unit: owns HI/LO, models multi-cycle latency
// and drives busy for the MD-class hazard stall.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] MD_out
);
    localparam logic [2:0] MD_MFHI  = 3'd0;
    localparam logic [2:0] MD_MFLO  = 3'd1;
    localparam logic [2:0] MD_MTHI  = 3'd2;
    localparam logic [2:0] MD_MTLO  = 3'd3;
    localparam logic [2:0] MD_MULT  = 3'd4;
    localparam logic [2:0] MD_MULTU = 3'd5;
    localparam logic [2:0] MD_DIV   = 3'd6;
    localparam logic [2:0] MD_DIVU  = 3'd7;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic            pend_vld_q, pend_vld_d;

    logic            is_mul, is_div, op_signed, a_neg, b_neg;
    logic [31:0]     a_mag, b_mag, div_b, quo_u, rem_u;
    logic [63:0]     prod_u;

    // Signed ops go through magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        is_mul    = (MDop == MD_MULT) || (MDop == MD_MULTU);
        is_div    = (MDop == MD_DIV) || (MDop == MD_DIVU);
        op_signed = (MDop == MD_MULT) || (MDop == MD_DIV);
        a_neg     = op_signed & A[31];
        b_neg     = op_signed & B[31];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        div_b     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        prod_u    = {32'd0, a_mag} * {32'd0, b_mag};
        quo_u     = a_mag / div_b;
        rem_u     = a_mag % div_b;
    end

    assign state = (cnt_q == '0) ? IDLE : RUN;

    always_comb begin
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_vld_d = pend_vld_q;
        unique case (state)
            IDLE: begin
                if (start && is_mul) begin
                    cnt_d      = CW'(MULT_CYCLES);
                    pend_vld_d = 1'b1;
                    {pend_hi_d, pend_lo_d} = (a_neg ^ b_neg) ? -prod_u : prod_u;
                end else if (start && is_div) begin
                    cnt_d      = CW'(DIV_CYCLES);
                    pend_vld_d = (B != 32'd0);
                    pend_lo_d  = (a_neg ^ b_neg) ? -quo_u : quo_u;
                    pend_hi_d  = a_neg ? -rem_u : rem_u;
                end else if (!start && MDop == MD_MTHI) begin
                    hi_d = A;
                end else if (!start && MDop == MD_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign busy   = start | (cnt_q != '0);
    assign HI_out = hi_q;
    assign LO_out = lo_q;
    assign MD_out = (MDop == MD_MFHI) ? hi_q :
                    (MDop == MD_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random traffic
// against a cycle-indexed arithmetic reference model.
module tb_md_unit;
    localparam logic [2:0] MFHI = 3'd0, MFLO = 3'd1, MTHI = 3'd2, MTLO = 3'd3;
    localparam logic [2:0] MULT = 3'd4, MULTU = 3'd5, DIV = 3'd6, DIVU = 3'd7;
    localparam int NM = 5, ND = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MDop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI_out, LO_out, MD_out;

    int n_cmp = 0;
    int n_bad = 0;

    longint      cyc = 0, done_at = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_ph = 0, m_pl = 0;
    bit          m_pv = 0;

    md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .start(start), .MDop(MDop),
        .A(A), .B(B), .busy(busy), .HI_out(HI_out),
        .LO_out(LO_out), .MD_out(MD_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_pv = 0; done_at = cyc;
    endtask

    // One posedge of the reference: result lands N posedges after start.
    task automatic model_edge(input bit s, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        bit idle;
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, pu;
        idle = (cyc >= done_at);
        cyc++;
        if (!idle && cyc == done_at) begin
            if (m_pv) begin m_hi = m_ph; m_lo = m_pl; end
            m_pv = 0;
        end
        if (idle) begin
            sa = $signed(a); sb = $signed(b);
            ua = a; ub = b;
            if (s && op == MULT) begin
                p = sa * sb; m_ph = p[63:32]; m_pl = p[31:0];
                m_pv = 1; done_at = cyc + NM;
            end else if (s && op == MULTU) begin
                pu = ua * ub; m_ph = pu[63:32]; m_pl = pu[31:0];
                m_pv = 1; done_at = cyc + NM;
            end else if (s && (op == DIV || op == DIVU)) begin
                m_pv = (b != 0); done_at = cyc + ND;
                if (b != 0) begin
                    if (op == DIV) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(ua / ub); r = longint'(ua % ub); end
                    m_pl = q[31:0]; m_ph = r[31:0];
                end
            end else if (!s && op == MTHI) m_hi = a;
            else if (!s && op == MTLO) m_lo = a;
        end
    endtask

    task automatic cyc_io(input bit s, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_md;
        start = s; MDop = op; A = a; B = b;
        @(negedge clk);
        exp_md = (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0;
        check("busy", {31'd0, busy}, {31'd0, s | (cyc < done_at)});
        check("hi", HI_out, m_hi);
        check("lo", LO_out, m_lo);
        check("md_out", MD_out, exp_md);
        @(posedge clk);
        model_edge(s, op, a, b);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc_io(0, MFLO, 0, 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 9);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 0; start = 0; MDop = MFHI; A = 0; B = 0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI_out, 32'd0);
        check("rst_lo", LO_out, 32'd0);
        check("rst_md", MD_out, 32'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); model_edge(0, MFHI, 0, 0); #1;

        cyc_io(1, MULT, 32'hFFFF_FFFE, 32'd3);
        idle_n(NM);
        check("t1_hi", HI_out, 32'hFFFF_FFFF);
        check("t1_lo", LO_out, 32'hFFFF_FFFA);

        cyc_io(1, MULTU, 32'hFFFF_FFFF, 32'd2);
        idle_n(NM);
        check("t2_hi", HI_out, 32'h0000_0001);
        cyc_io(0, MFLO, 0, 0);
        check("t2_mflo", MD_out, 32'hFFFF_FFFE);

        cyc_io(1, DIV, -32'sd7, 32'd2);
        idle_n(ND);
        check("t3_lo", LO_out, 32'hFFFF_FFFD);
        check("t3_hi", HI_out, 32'hFFFF_FFFF);
        cyc_io(1, DIVU, 32'd7, 32'd2);
        idle_n(ND);
        check("t3u_lo", LO_out, 32'd3);
        check("t3u_hi", HI_out, 32'd1);

        cyc_io(1, DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_n(ND);
        check("ovf_lo", LO_out, 32'h8000_0000);
        check("ovf_hi", HI_out, 32'd0);

        cyc_io(0, MTHI, 32'h1234_5678, 0);
        cyc_io(0, MTLO, 32'd0, 0);
        cyc_io(1, DIV, 32'd5, 32'd0);
        idle_n(ND);
        check("t4_hi", HI_out, 32'h1234_5678);
        check("t4_lo", LO_out, 32'd0);

        cyc_io(1, MULT, 32'd3, 32'd4);
        idle_n(NM - 2);
        #3;
        start = 0; MDop = MFHI; reset = 0;
        #1;
        model_reset();
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_hi", HI_out, 32'd0);
        check("t5_lo", LO_out, 32'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); model_edge(0, MFHI, 0, 0); #1;
        cyc_io(0, MTLO, 32'd9, 0);
        cyc_io(0, MFLO, 0, 0);
        check("t5_mtlo", LO_out, 32'd9);

        cyc_io(1, MULT, 32'd5, 32'd6);
        cyc_io(1, MULT, 32'd7, 32'd8);
        cyc_io(0, MTLO, 32'd1, 0);
        idle_n(NM);
        check("t6_hi", HI_out, 32'd0);
        check("t6_lo", LO_out, 32'd30);

        for (int i = 0; i < 600; i++)
            cyc_io($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                   rnd_val(), rnd_val());
        idle_n(ND + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
